// File: rtl/fib_seq.sv
// rtl/fib_seq.sv - generalised Fibonacci sequence engine with result and streaming modes
//
// Computes F(i)=F(i-1)+F(i-2) from programmable seeds F(0)=seed0, F(1)=seed1.
// Optional build macro: FIB_SEQ_SATURATE_EN (terms clamp to all-ones after a carry).
//
// Ports:
//   clk, rst              clock and asynchronous active-high reset
//   go, n, seed0, seed1,  start request and operands, sampled when go is accepted
//   stream                0 = final result only, 1 = emit F(0)..F(n)
//   busy                  high while computing or emitting
//   out_valid, out_ready, stream beat handshake, term data and final-beat marker
//   out_data, out_last
//   result, done          F(n) and level done flag
//   overflow              sticky: some term F(2)..F(n) carried out of OUTPUT_WIDTH
module fib_seq #(
  parameter int INPUT_WIDTH  = 6,
  parameter int OUTPUT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    go,
  input  logic [INPUT_WIDTH-1:0]  n,
  input  logic [OUTPUT_WIDTH-1:0] seed0,
  input  logic [OUTPUT_WIDTH-1:0] seed1,
  input  logic                    stream,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUTPUT_WIDTH-1:0] out_data,
  output logic                    out_last,
  output logic [OUTPUT_WIDTH-1:0] result,
  output logic                    overflow,
  output logic                    done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    EMIT    = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                  state_q;
  logic [OUTPUT_WIDTH-1:0] a_q;
  logic [OUTPUT_WIDTH-1:0] b_q;
  logic [INPUT_WIDTH-1:0]  cnt_q;
  logic [INPUT_WIDTH-1:0]  n_q;
  logic [OUTPUT_WIDTH-1:0] result_q;
  logic                    ovf_q;
  logic                    done_q;
  logic                    busy_q;
  logic                    valid_q;
  logic                    last_q;
`ifdef FIB_SEQ_SATURATE_EN
  logic                    sat_q;
`endif

  logic [OUTPUT_WIDTH:0]   sum_d;
  logic                    carry_d;
  logic [OUTPUT_WIDTH-1:0] term_d;
  logic [INPUT_WIDTH:0]    cnt_p2_d;
  logic                    emit_ovf_ok_d;

  always_comb begin
    sum_d   = {1'b0, a_q} + {1'b0, b_q};
    carry_d = sum_d[OUTPUT_WIDTH];
`ifdef FIB_SEQ_SATURATE_EN
    // Once any term has carried, every later term stays clamped.
    term_d  = (carry_d || sat_q) ? {OUTPUT_WIDTH{1'b1}} : sum_d[OUTPUT_WIDTH-1:0];
`else
    term_d  = sum_d[OUTPUT_WIDTH-1:0];
`endif
    // In EMIT the sum being formed is F(j+2); it only counts when j+2 <= n,
    // otherwise it is a look-ahead term that will never be emitted.
    cnt_p2_d      = {1'b0, cnt_q} + (INPUT_WIDTH+1)'(2);
    emit_ovf_ok_d = (cnt_p2_d <= {1'b0, n_q});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      n_q      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
`ifdef FIB_SEQ_SATURATE_EN
      sat_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (go) begin
            n_q    <= n;
            a_q    <= seed0;
            b_q    <= seed1;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b1;
`ifdef FIB_SEQ_SATURATE_EN
            sat_q  <= 1'b0;
`endif
            if (stream) begin
              state_q <= EMIT;
              cnt_q   <= '0;
              valid_q <= 1'b1;
              last_q  <= (n == '0);
            end else begin
              state_q <= COMPUTE;
              cnt_q   <= INPUT_WIDTH'(1);
            end
          end
        end

        COMPUTE: begin
          if (cnt_q < n_q) begin
            a_q   <= b_q;
            b_q   <= term_d;
            cnt_q <= cnt_q + 1'b1;
            if (carry_d) begin
              ovf_q <= 1'b1;
`ifdef FIB_SEQ_SATURATE_EN
              sat_q <= 1'b1;
`endif
            end
          end else begin
            // Counter starts at 1, so n=0 must take F(0) from a rather than b.
            result_q <= (n_q == '0) ? a_q : b_q;
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end
        end

        EMIT: begin
          if (out_ready) begin
            if (last_q) begin
              result_q <= a_q;
              state_q  <= DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              valid_q  <= 1'b0;
              last_q   <= 1'b0;
            end else begin
              a_q    <= b_q;
              b_q    <= term_d;
              cnt_q  <= cnt_q + 1'b1;
              last_q <= ((cnt_q + 1'b1) == n_q);
              if (carry_d && emit_ovf_ok_d) begin
                ovf_q <= 1'b1;
              end
`ifdef FIB_SEQ_SATURATE_EN
              if (carry_d) begin
                sat_q <= 1'b1;
              end
`endif
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign out_data  = a_q;
  assign out_last  = last_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign done      = done_q;

endmodule

// File: doc/fib_seq.md
# fib_seq

Parametrised successor to the team's Fibonacci core. It computes generalised Fibonacci sequences with programmable seeds, so Fibonacci, Lucas and arbitrary recurrences all use one engine. It adds a streaming mode that emits every term F(0)..F(n) over a valid/ready handshake, and keeps the legacy go/result/done interface. It sits beside the existing fib wrapper as a drop-in, higher-capability sequence source for downstream test and datapath blocks.

## Interface
- INPUT_WIDTH, default 6: width of index n.
- OUTPUT_WIDTH, default 32: width of seeds, terms and result.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- go  in  1  start request; accepted only when busy=0.
- n  in  INPUT_WIDTH  index of final term; sampled on go acceptance.
- seed0  in  OUTPUT_WIDTH  F(0); sampled on go acceptance.
- seed1  in  OUTPUT_WIDTH  F(1); sampled on go acceptance.
- stream  in  1  mode, sampled on go acceptance.
  - 0 = final result only.
  - 1 = emit all terms.
- busy  out  1  high in COMPUTE/EMIT.
- out_valid  out  1  stream beat valid.
- out_ready  in  1  downstream accepts beat.
- out_data  out  OUTPUT_WIDTH  current streamed term.
- out_last  out  1  marks beat F(n).
- result  out  OUTPUT_WIDTH  F(n); valid while done=1.
- overflow  out  1  any term F(2)..F(n) exceeded OUTPUT_WIDTH.
- done  out  1  level; high in DONE until next go accepted.

## Operation
- Recurrence: F(i)=F(i-1)+F(i-2), with F(0)=seed0 and F(1)=seed1.
- Each sum is OUTPUT_WIDTH+1 bits wide. A carry-out sets overflow, which is sticky until the next accepted go.
  - The stored term wraps modulo 2^OUTPUT_WIDTH unless saturation is compiled in (see Configuration).
- Only additions that produce terms with index ≤ n affect overflow.
  - Look-ahead sums beyond F(n) are discarded.
  - n=0 and n=1 never overflow.
- States:
  - IDLE -> COMPUTE on go when stream=0.
  - IDLE -> EMIT on go when stream=1.
  - COMPUTE -> DONE after the final term is formed.
  - EMIT -> DONE on the handshake of the beat with out_last.
  - DONE -> COMPUTE/EMIT on go.
- COMPUTE holds registers a=F(i-1), b=F(i) and counter i, starting at i=1.
  - While i<n: a<=b, b<=a+b, i<=i+1.
  - When i≥n: result<=(n==0 ? a : b), then transition to DONE.
- EMIT holds registers a=F(j), b=F(j+1) and counter j, starting at j=0. Outputs are out_data=a, out_valid=1, out_last=(j==n).
  - On handshake (out_valid & out_ready): a<=b, b<=a+b, j<=j+1.
  - On the last beat: result<=a, then transition to DONE.
- Handshake rules:
  - out_valid never drops without a handshake.
  - out_data and out_last are stable while out_valid & !out_ready.
  - The recurrence stalls under backpressure.
- go while busy=1 is ignored: no effect on state, inputs not re-sampled.
- go in DONE clears done and overflow on the accepting edge.
- Reset, including mid-operation:
  - State returns to IDLE.
  - result=0, overflow=0, done=0, busy=0, out_valid=0, out_last=0, out_data=0.
  - Any in-flight beat is dropped.

## Timing
- G denotes the cycle in which go is sampled high with busy=0.
- Non-stream: busy=1 from G+1. done=1 and result valid in cycle G+max(n,1)+1.
- Stream: first beat valid in cycle G+1.
  - With out_ready held high, one beat per cycle; the n+1 beats occupy cycles G+1..G+n+1.
  - done=1 in the cycle after the last handshake.
- Back-to-back operation: go may be accepted in the first cycle done=1. The new operation starts in the following cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- FIB_SEQ_SATURATE_EN defined:
  - Any term whose sum carries out is stored as 2^OUTPUT_WIDTH-1.
  - All later terms are also stored as 2^OUTPUT_WIDTH-1.
  - overflow is set as normal.
- Not defined: terms wrap modulo 2^OUTPUT_WIDTH and overflow still reports the wrap.

## Test plan
- seed0=0, seed1=1, n=10, stream=0 -> done in cycle G+11, result=55, overflow=0.
- Defaults, n=47 -> result=2971215073, overflow=0.
- Defaults, n=48 without the macro -> result=512559680, overflow=1.
- Defaults, n=48 with FIB_SEQ_SATURATE_EN -> result=0xFFFFFFFF, overflow=1.
- seed0=2, seed1=1, n=5, stream=1, out_ready=1 -> out_data 2,1,3,4,7,11 in cycles G+1..G+6.
  - out_last only on 11.
  - done at G+7, result=11.
- Same stream with out_ready toggled pseudo-randomly:
  - identical beat sequence, no drops or duplicates;
  - out_data stable during stalls.
- n=0, seed0=7 -> non-stream: result=7 with done at G+2; stream: single beat 7 with out_last=1.
- Edge cases:
  - go pulsed while busy=1 -> ignored.
  - rst asserted mid-COMPUTE -> all outputs 0 immediately.
  - A subsequent go with n=3 (defaults) -> result=2.
